// File: rtl/seg_scan_driver.sv
// Multiplexed seven-segment scanner with double-buffered content, PWM brightness,
// per-digit blink and a dead cycle at the start of every digit slot.
module seg_scan_driver #(
    parameter int DIGITS       = 8,
    parameter int SCAN_DIV     = 1024,
    parameter int BLINK_FRAMES = 128
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [4*DIGITS-1:0]   data,
    input  logic [DIGITS-1:0]     dp,
    input  logic [DIGITS-1:0]     enable,
    input  logic [DIGITS-1:0]     blink,
    input  logic [3:0]            brightness,
    input  logic                  load_req,
    output logic                  load_ack,
    output logic                  frame_tick,
    output logic [DIGITS-1:0]     cat,
    output logic [7:0]            seg
);

    localparam int SC_W      = $clog2(SCAN_DIV);
    localparam int IDX_W     = $clog2(DIGITS);
    localparam int BC_W      = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam int DUTY_STEP = SCAN_DIV / 16;

    localparam logic [SC_W-1:0]  SC_LAST  = SC_W'(SCAN_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);
    localparam logic [BC_W-1:0]  BC_LAST  = BC_W'(BLINK_FRAMES - 1);

    function automatic logic [6:0] hex7(input logic [3:0] n);
        case (n)
            4'h0: hex7 = 7'h3F;
            4'h1: hex7 = 7'h06;
            4'h2: hex7 = 7'h5B;
            4'h3: hex7 = 7'h4F;
            4'h4: hex7 = 7'h66;
            4'h5: hex7 = 7'h6D;
            4'h6: hex7 = 7'h7D;
            4'h7: hex7 = 7'h07;
            4'h8: hex7 = 7'h7F;
            4'h9: hex7 = 7'h6F;
            4'hA: hex7 = 7'h77;
            4'hB: hex7 = 7'h7C;
            4'hC: hex7 = 7'h39;
            4'hD: hex7 = 7'h5E;
            4'hE: hex7 = 7'h79;
            default: hex7 = 7'h71;
        endcase
    endfunction

    logic [SC_W-1:0]     sc_q, sc_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [BC_W-1:0]     blink_cnt_q, blink_cnt_d;
    logic                hidden_q, hidden_d;
    logic [4*DIGITS-1:0] data_sh_q, data_sh_d;
    logic [DIGITS-1:0]   dp_sh_q, dp_sh_d;
    logic [DIGITS-1:0]   en_sh_q, en_sh_d;
    logic [DIGITS-1:0]   blink_sh_q, blink_sh_d;
    logic [3:0]          bright_sh_q, bright_sh_d;
    logic                load_ack_q, load_ack_d;
    logic                frame_tick_q, frame_tick_d;
    logic [DIGITS-1:0]   cat_q, cat_d;
    logic [7:0]          seg_q, seg_d;

    logic                boundary;
    logic                lit;
    logic [SC_W:0]       duty;

    always_comb begin
        sc_d         = sc_q;
        idx_d        = idx_q;
        blink_cnt_d  = blink_cnt_q;
        hidden_d     = hidden_q;
        data_sh_d    = data_sh_q;
        dp_sh_d      = dp_sh_q;
        en_sh_d      = en_sh_q;
        blink_sh_d   = blink_sh_q;
        bright_sh_d  = bright_sh_q;
        cat_d        = '1;
        seg_d        = '0;

        boundary = (sc_q == SC_LAST) && (idx_q == IDX_LAST);
        duty     = (SC_W + 1)'((32'(bright_sh_q) + 32'd1) * 32'(DUTY_STEP));

        // sc = 0 stays dark so the previous digit's segments never bleed into this one
        lit = (sc_q != '0) && ({1'b0, sc_q} < duty) && en_sh_q[idx_q]
              && !(blink_sh_q[idx_q] && hidden_q);

        if (lit) begin
            cat_d = ~(DIGITS'(1) << idx_q);
            seg_d = {dp_sh_q[idx_q], hex7(data_sh_q[{idx_q, 2'b00} +: 4])};
        end

        if (sc_q == SC_LAST) begin
            sc_d  = '0;
            idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
        end else begin
            sc_d = sc_q + 1'b1;
        end

        if (boundary) begin
            if (blink_cnt_q == BC_LAST) begin
                blink_cnt_d = '0;
                hidden_d    = ~hidden_q;
            end else begin
                blink_cnt_d = blink_cnt_q + 1'b1;
            end
        end

        // Content is only committed between frames so a frame is never torn
        if (boundary && load_req) begin
            data_sh_d   = data;
            dp_sh_d     = dp;
            en_sh_d     = enable;
            blink_sh_d  = blink;
            bright_sh_d = brightness;
        end

        load_ack_d   = boundary && load_req;
        frame_tick_d = boundary;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sc_q         <= '0;
            idx_q        <= '0;
            blink_cnt_q  <= '0;
            hidden_q     <= 1'b0;
            data_sh_q    <= '0;
            dp_sh_q      <= '0;
            en_sh_q      <= '0;
            blink_sh_q   <= '0;
            bright_sh_q  <= '0;
            load_ack_q   <= 1'b0;
            frame_tick_q <= 1'b0;
            cat_q        <= '1;
            seg_q        <= '0;
        end else begin
            sc_q         <= sc_d;
            idx_q        <= idx_d;
            blink_cnt_q  <= blink_cnt_d;
            hidden_q     <= hidden_d;
            data_sh_q    <= data_sh_d;
            dp_sh_q      <= dp_sh_d;
            en_sh_q      <= en_sh_d;
            blink_sh_q   <= blink_sh_d;
            bright_sh_q  <= bright_sh_d;
            load_ack_q   <= load_ack_d;
            frame_tick_q <= frame_tick_d;
            cat_q        <= cat_d;
            seg_q        <= seg_d;
        end
    end

    assign load_ack   = load_ack_q;
    assign frame_tick = frame_tick_q;
    assign cat        = cat_q;
    assign seg        = seg_q;

endmodule

// File: doc/seg_scan_driver.md
Name: seg_scan_driver

Overview:
- Parametrised multiplexed seven-segment scanner; next generation of the fixed 8-digit hex driver behind the seg driver.
- Scans DIGITS common-cathode digits and provides per-digit enable, decimal point and blink, plus global PWM brightness and an anti-ghosting dead cycle.
- Display content is double-buffered. A load_req/load_ack handshake commits new content only on a frame boundary, so a frame is never torn.

Parameters:
- DIGITS, 8, number of digits scanned; must be ≥ 2.
- SCAN_DIV, 1024, clk cycles per digit slot; must be a multiple of 16 and ≥ 32.
- BLINK_FRAMES, 128, number of frames per blink half-period; must be ≥ 1.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  synchronous reset, active-low.
- data  input  4*DIGITS  hex nibble per digit; digit i = data[4i+3:4i].
- dp  input  DIGITS  decimal point per digit, active-high.
- enable  input  DIGITS  per-digit display enable, active-high.
- blink  input  DIGITS  per-digit blink enable, active-high.
- brightness  input  4  global duty: 0 = dimmest, 15 = full.
- load_req  input  1  request to commit data/dp/enable/blink/brightness into the shadow set; held high until load_ack.
- load_ack  output  1  one-cycle pulse: shadow set updated.
- frame_tick  output  1  one-cycle pulse at each frame end.
- cat  output  DIGITS  digit select, active-low; cat[i] drives digit i.
- seg  output  8  segments {dp,g,f,e,d,c,b,a}, active-high.

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - slot counter sc=0, digit index idx=0, blink counter=0, blink phase=visible.
  - Shadow set cleared: all enables 0, brightness 0.
  - Outputs: cat all ones, seg=0, load_ack=0, frame_tick=0.
  - Reset mid-frame aborts the frame. A pending load_req is dropped; the requester must keep it asserted.
- Counters:
  - sc counts 0..SCAN_DIV-1 and wraps.
  - idx increments 0→DIGITS-1 on each sc wrap, then wraps to 0.
  - A frame boundary is the cycle where sc=SCAN_DIV-1 and idx=DIGITS-1.
- Duty: duty = (brightness_shadow+1)*(SCAN_DIV/16).
- Digit idx is lit when all of the following hold; otherwise blanked (cat all ones, seg=0):
  - 1 ≤ sc < duty (sc=0 is always a dead cycle against ghosting);
  - enable_shadow[idx]=1;
  - NOT (blink_shadow[idx]=1 AND blink phase=hidden).
- When lit: cat has only bit idx low; seg[6:0] = hex decode of nibble idx; seg[7] = dp_shadow[idx].
- Output latency: cat and seg are registered, so they reflect the sc/idx values of the previous cycle (1-cycle latency).
- Hex decode (gfedcba):
  - 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07
  - 8=7F, 9=6F, A=77, b=7C, C=39, d=5E, E=79, F=71
- Blink: the blink counter increments at each frame boundary. On reaching BLINK_FRAMES-1 it wraps to 0 and toggles the phase. The first phase after reset is visible.
- Load handshake:
  - At a frame boundary edge with load_req=1, the shadow set captures all content inputs.
  - load_ack=1 in the next cycle only; frame_tick pulses in that same cycle.
  - load_req rising exactly on the boundary cycle is honoured.
  - load_req still high after load_ack causes a reload at every subsequent boundary, with an ack each time.
  - Inputs changing between boundaries have no visible effect.
- frame_tick: pulses one cycle after every frame boundary, whether or not a load occurred.
- Brightness 15: digit lit for sc=1..SCAN_DIV-1. Brightness 0: lit for sc=1..SCAN_DIV/16-1.

Test Plan (DIGITS=8, SCAN_DIV=32, BLINK_FRAMES=2):
1. Reset hold 3 cycles, then release with no load -> cat=FF, seg=00 for 2 full frames (512 cycles); frame_tick every 256 cycles, first pulse at cycle 256 after release.
2. load_req=1 with data=32'h1234_5678, enable=FF, brightness=15 -> load_ack at cycle 256. In the next frame, digit 0 slot: cat=FE, seg=7F for slot cycles 1..31 and FF/00 in the dead cycle; digit 7 shows seg=06.
3. brightness=0, enable=01 loaded -> digit 0 lit exactly sc=1 (duty=2), i.e. 1 lit cycle per 256; all other cycles blank.
4. blink=01, enable=01, dp=01, data nibble0=A -> seg=F7 for frames 0–1, blank for frames 2–3, lit again at frame 4.
5. Change data mid-frame with load_req=0 -> display unchanged. Assert load_req on the boundary cycle itself -> ack next cycle, new value shown from next frame's digit 0.
6. Assert rst_n=0 during digit 4 slot with load_req high -> next cycle cat=FF, seg=00, load_ack=0. After release, shadow is empty until the next boundary ack.
